// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and defaults for the arbiter requester
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GRANT = 2'd2,
        COOL  = 2'd3
    } arb_req_state_e;

    localparam int ARB_NUM_CH       = 4;
    localparam int ARB_TIMEOUT_GNT  = 10;
    localparam int ARB_MAX_GNT_HOLD = 3;

endpackage

// File: rtl/arb_req_chan.sv
// rtl/arb_req_chan.sv - one requester channel: FSM, wait/hold timers, saturating grant counter
module arb_req_chan
    import arb_pkg::*;
#(
    parameter int TIMEOUT_GNT  = ARB_TIMEOUT_GNT,
    parameter int MAX_GNT_HOLD = ARB_MAX_GNT_HOLD,
    parameter int CNT_W        = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start_i,
    input  logic             gnt_i,
    output logic             req_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             tout_o,
    output logic [CNT_W-1:0] cnt_o,
    output arb_req_state_e   state_o
);

    localparam int WAIT_W = (TIMEOUT_GNT > 1) ? $clog2(TIMEOUT_GNT) : 1;
    localparam int HOLD_W = (MAX_GNT_HOLD > 1) ? $clog2(MAX_GNT_HOLD) : 1;

    arb_req_state_e    state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tout_q, tout_d;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        tout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                wait_d = '0;
                if (start_i) state_d = REQ;
            end
            REQ: begin
                // a grant sampled on the timeout edge still counts as on time
                if (gnt_i) begin
                    state_d = GRANT;
                    hold_d  = '0;
                end else if (wait_q == WAIT_W'(TIMEOUT_GNT - 1)) begin
                    state_d = COOL;
                    tout_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            GRANT: begin
                if (!gnt_i) begin
                    state_d = COOL;
                    done_d  = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end else if (hold_q == HOLD_W'(MAX_GNT_HOLD - 1)) begin
                    state_d = COOL;
                    tout_d  = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            COOL: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_d  = (state_d == REQ) || (state_d == GRANT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
        end
    end

    assign req_o   = req_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign tout_o  = tout_q;
    assign cnt_o   = cnt_q;
    assign state_o = state_q;

endmodule

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - four-channel requester engine with grant protocol checking
module arb_requester
    import arb_pkg::*;
#(
    parameter int TIMEOUT_GNT  = ARB_TIMEOUT_GNT,
    parameter int MAX_GNT_HOLD = ARB_MAX_GNT_HOLD,
    parameter int CNT_W        = 8
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic [ARB_NUM_CH-1:0]       start,
    input  logic                        gnt1,
    input  logic                        gnt2,
    input  logic                        gnt3,
    input  logic                        gnt4,
    output logic                        req1,
    output logic                        req2,
    output logic                        req3,
    output logic                        req4,
    output logic [ARB_NUM_CH-1:0]       busy,
    output logic [ARB_NUM_CH-1:0]       done,
    output logic [ARB_NUM_CH-1:0]       tout,
    output logic [ARB_NUM_CH*CNT_W-1:0] gnt_cnt,
    output logic                        multi_gnt_err,
    output logic                        spurious_err
);

    logic [ARB_NUM_CH-1:0] gnt_v;
    logic [ARB_NUM_CH-1:0] req_v;
    logic [ARB_NUM_CH-1:0] unowned_v;
    arb_req_state_e        state_v [ARB_NUM_CH];
    logic                  multi_q, multi_d;
    logic                  spur_q, spur_d;

    assign gnt_v = {gnt4, gnt3, gnt2, gnt1};

    for (genvar i = 0; i < ARB_NUM_CH; i++) begin : g_chan
        arb_req_chan #(
            .TIMEOUT_GNT (TIMEOUT_GNT),
            .MAX_GNT_HOLD(MAX_GNT_HOLD),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clock  (clock),
            .rst    (rst),
            .start_i(start[i]),
            .gnt_i  (gnt_v[i]),
            .req_o  (req_v[i]),
            .busy_o (busy[i]),
            .done_o (done[i]),
            .tout_o (tout[i]),
            .cnt_o  (gnt_cnt[i*CNT_W +: CNT_W]),
            .state_o(state_v[i])
        );
        assign unowned_v[i] = gnt_v[i] && ((state_v[i] == IDLE) || (state_v[i] == COOL));
    end

    // clearing the lowest set bit leaves something only when two or more grants are high
    always_comb begin
        multi_d = multi_q || ((gnt_v & (gnt_v - 4'd1)) != '0);
        spur_d  = spur_q || (|unowned_v);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            multi_q <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            multi_q <= multi_d;
            spur_q  <= spur_d;
        end
    end

    assign {req4, req3, req2, req1} = req_v;
    assign multi_gnt_err = multi_q;
    assign spurious_err  = spur_q;

endmodule
